// File: rtl/bus_downsizer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_downsizer
//  Purpose  : Wide-to-narrow valid/ready width converter. Each S_DATA_WIDTH
//             word is split into RATIO = S_DATA_WIDTH/M_DATA_WIDTH narrow
//             beats, most-significant slice first, with one beat per cycle
//             and no bubble between consecutive words.
//  Options  : BUS_DOWNSIZER_LAST_EN - adds output m_last, high on the final
//             beat of each wide word.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_downsizer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_val,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  output logic                    s_rdy,
  output logic                    m_val,
  output logic [M_DATA_WIDTH-1:0] m_data,
`ifdef BUS_DOWNSIZER_LAST_EN
  output logic                    m_last,
`endif
  input  logic                    m_rdy
);

  localparam int C_RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int C_CNT_W = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_RATIO - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Reject configurations that cannot be split into at least two whole beats.
  if ((C_RATIO < 2) || (S_DATA_WIDTH % M_DATA_WIDTH != 0)) begin : g_bad_ratio
    $error("bus_downsizer: S_DATA_WIDTH must be an integer multiple (>=2) of M_DATA_WIDTH");
  end

  logic [0:0]              r_state;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [S_DATA_WIDTH-1:0] r_hold;

  logic w_last_beat;
  logic w_s_rdy;

  // Final beat of the held word is on the bus; its handshake frees the holding register.
  always_comb begin
    w_last_beat = (r_state == ST_SEND) && (r_cnt == C_CNT_LAST);
    w_s_rdy     = !reset && ((r_state == ST_IDLE) || (w_last_beat && m_rdy));
  end

  assign s_rdy  = w_s_rdy;
  assign m_val  = (r_state == ST_SEND);
  assign m_data = r_hold[S_DATA_WIDTH-1 -: M_DATA_WIDTH];

`ifdef BUS_DOWNSIZER_LAST_EN
  assign m_last = w_last_beat;
`endif

  // Word load, beat shifting and beat counting; reset discards any partial word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_val) begin
            r_hold  <= s_data;
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_rdy) begin
            if (r_cnt != C_CNT_LAST) begin
              r_hold <= r_hold << M_DATA_WIDTH;
              r_cnt  <= r_cnt + C_CNT_W'(1);
            end else if (s_val) begin
              // Next word enters in the same cycle the last beat leaves: no bubble.
              r_hold <= s_data;
              r_cnt  <= '0;
            end else begin
              r_hold  <= r_hold << M_DATA_WIDTH;
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_downsizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_downsizer
//  Purpose  : Self-checking bench for bus_downsizer (32->8 and 24->8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_downsizer;

  logic        clock;
  logic        reset;

  logic        s_val;
  logic [31:0] s_data;
  logic        s_rdy;
  logic        m_val;
  logic [7:0]  m_data;
  logic        m_rdy;
  logic        m_last;

  logic        s_val2;
  logic [23:0] s_data2;
  logic        s_rdy2;
  logic        m_val2;
  logic [7:0]  m_data2;
  logic        m_rdy2;
  logic        m_last2;

  int n_checks;
  int n_fail;

  bus_downsizer #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val),
    .s_data (s_data),
    .s_rdy  (s_rdy),
    .m_val  (m_val),
    .m_data (m_data),
`ifdef BUS_DOWNSIZER_LAST_EN
    .m_last (m_last),
`endif
    .m_rdy  (m_rdy)
  );

  bus_downsizer #(.S_DATA_WIDTH(24), .M_DATA_WIDTH(8)) dut24 (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val2),
    .s_data (s_data2),
    .s_rdy  (s_rdy2),
    .m_val  (m_val2),
    .m_data (m_data2),
`ifdef BUS_DOWNSIZER_LAST_EN
    .m_last (m_last2),
`endif
    .m_rdy  (m_rdy2)
  );

`ifndef BUS_DOWNSIZER_LAST_EN
  assign m_last  = 1'b0;
  assign m_last2 = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        s_val;
    logic [31:0] s_data;
    logic        m_rdy;
    logic        m_val;
    logic [7:0]  m_data;
    logic        s_rdy;
    logic        last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic mr,
                              logic mv, logic [7:0] md, logic sr, logic ml);
    vec_t v;
    v.s_val = sv; v.s_data = sd; v.m_rdy = mr;
    v.m_val = mv; v.m_data = md; v.s_rdy = sr; v.last = ml;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] beats [0:15];
    int         nb;
    logic [7:0] exp4 [0:3];
    logic [7:0] exp3 [0:2];
    logic       saw_last_wrap;

    n_checks = 0;
    n_fail   = 0;
    reset   = 1'b1;
    s_val   = 1'b0; s_data  = '0; m_rdy  = 1'b0;
    s_val2  = 1'b0; s_data2 = '0; m_rdy2 = 1'b0;

    // Word 1 (A1B2C3D4), back-to-back 0102 0304/0506 0708, backpressure on DEADBEEF.
    vecs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hA1, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hB2, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hD4, 1, 1));
    vecs.push_back(mk(1, 32'h01020304, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 32'h05060708, 1, 1, 8'h01, 0, 0));
    vecs.push_back(mk(1, 32'h05060708, 1, 1, 8'h02, 0, 0));
    vecs.push_back(mk(1, 32'h05060708, 1, 1, 8'h03, 0, 0));
    vecs.push_back(mk(1, 32'h05060708, 1, 1, 8'h04, 1, 1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h05, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h06, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h07, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h08, 1, 1));
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hDE, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 0, 1, 8'hAD, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 8'hAD, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 8'hAD, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hAD, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hBE, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 8'hEF, 0, 1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hEF, 1, 1));
    vecs.push_back(mk(0, 32'h0,        1, 0, 8'h00, 1, 0));

    // Reset state
    #2;
    check("reset_m_val",  {31'b0, m_val},  32'h0);
    check("reset_m_data", {24'b0, m_data}, 32'h0);
    check("reset_s_rdy",  {31'b0, s_rdy},  32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      s_val  = vecs[i].s_val;
      s_data = vecs[i].s_data;
      m_rdy  = vecs[i].m_rdy;
      @(negedge clock);
      check($sformatf("vec%0d_m_val", i), {31'b0, m_val}, {31'b0, vecs[i].m_val});
      check($sformatf("vec%0d_s_rdy", i), {31'b0, s_rdy}, {31'b0, vecs[i].s_rdy});
      if (vecs[i].m_val)
        check($sformatf("vec%0d_m_data", i), {24'b0, m_data}, {24'b0, vecs[i].m_data});
`ifdef BUS_DOWNSIZER_LAST_EN
      check($sformatf("vec%0d_m_last", i), {31'b0, m_last}, {31'b0, vecs[i].last});
`endif
      @(posedge clock); #1;
    end
    s_val = 1'b0; m_rdy = 1'b1;

    // Asynchronous reset in the middle of word 11223344
    s_val = 1'b1; s_data = 32'h11223344;
    @(posedge clock); #1;
    s_val = 1'b0; s_data = '0;
    @(negedge clock);
    check("rst_seq_beat11", {24'b0, m_data}, 32'h11);
    @(posedge clock); #1;
    check("rst_seq_beat22_pending", {31'b0, m_val}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_m_val",  {31'b0, m_val},  32'h0);
    check("rst_async_m_data", {24'b0, m_data}, 32'h0);
    check("rst_async_s_rdy",  {31'b0, s_rdy},  32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_s_rdy", {31'b0, s_rdy}, 32'h1);
    check("rst_release_m_val", {31'b0, m_val}, 32'h0);
    s_val = 1'b1; s_data = 32'h55667788;
    @(posedge clock); #1;
    s_val = 1'b0; s_data = '0;
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (m_val && m_rdy && nb < 16) begin
        beats[nb] = m_data;
        nb++;
      end
      @(posedge clock); #1;
    end
    exp4[0] = 8'h55; exp4[1] = 8'h66; exp4[2] = 8'h77; exp4[3] = 8'h88;
    check("post_reset_beat_count", nb, 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("post_reset_beat%0d", k), {24'b0, beats[k]}, {24'b0, exp4[k]});

    // Non-power-of-2 ratio: 24 -> 8
    m_rdy2 = 1'b1;
    s_val2 = 1'b1; s_data2 = 24'hABCDEF;
    @(negedge clock);
    check("r3_idle_s_rdy", {31'b0, s_rdy2}, 32'h1);
    @(posedge clock); #1;
    s_val2 = 1'b0; s_data2 = '0;
    nb = 0;
    saw_last_wrap = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (m_val2 && nb < 16) begin
        beats[nb] = m_data2;
        if (nb == 2) saw_last_wrap = s_rdy2;
`ifdef BUS_DOWNSIZER_LAST_EN
        check($sformatf("r3_m_last%0d", nb), {31'b0, m_last2}, (nb == 2) ? 32'h1 : 32'h0);
`endif
        nb++;
      end
      @(posedge clock); #1;
    end
    exp3[0] = 8'hAB; exp3[1] = 8'hCD; exp3[2] = 8'hEF;
    check("r3_beat_count", nb, 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("r3_beat%0d", k), {24'b0, beats[k]}, {24'b0, exp3[k]});
    check("r3_s_rdy_on_final_beat", {31'b0, saw_last_wrap}, 32'h1);
    check("r3_idle_after", {31'b0, m_val2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
